bcd_serial_digit_sequencer: RTL and testbench

Controller that shares one single-digit BCD adder slice (A + B + carry) across all digits of two multi-digit BCD operands, processing one digit per clock from least significant to most significant. It latches operands on a start request and propagates the decimal carry between digits. It asserts a one-cycle done pulse with the packed BCD sum, final carry and an invalid-digit flag. It sits between the switch/operand capture logic and the seven-segment display drivers, replacing a wide combinational sum/modulo path with a sequenced one.

---
 rtl/bcd_serial_digit_sequencer.sv | 130 +++++++++++++
 tb/tb_bcd_serial_digit_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_digit_sequencer.sv
// bcd_serial_digit_sequencer
//
// Adds two packed multi-digit BCD operands with one shared single-digit
// BCD adder slice, one digit per clock, least significant digit first.
// The operands and the incoming carry are captured when a request is
// accepted, so the inputs may change while the addition runs.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, clears all state
//   start     begin an addition (sampled only while idle)
//   a, b      packed BCD operands, digit 0 in bits [3:0]
//   carry_in  carry into digit 0
//   busy      high while digits are being processed
//   done      one-cycle pulse; results valid from this cycle on
//   sum       packed BCD result (partially updated while busy)
//   carry_out decimal carry out of the most significant digit
//   error     set when any operand digit is above 9; held until next start
module bcd_serial_digit_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  error
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One BCD digit: returns {carry, digit}. A raw sum above 9 gets the
    // decimal correction of +6; this also applies to invalid digits so the
    // result stays deterministic when error is flagged.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                  input logic [3:0] y,
                                                  input logic       cin);
        logic [4:0] s;
        s = 5'(x) + 5'(y) + 5'(cin);
        if (s > 5'd9)
            bcd_digit_add = {1'b1, s[3:0] + 4'd6};
        else
            bcd_digit_add = {1'b0, s[3:0]};
    endfunction

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [4*DIGITS-1:0]   a_q;
    logic [4*DIGITS-1:0]   b_q;

    logic [3:0]            a_dig;
    logic [3:0]            b_dig;
    logic [4:0]            slice;
    logic                  bad_dig;
    logic                  last_dig;

    // Shared digit slice, fed from the latched operands at the current index.
    assign a_dig    = a_q[{idx, 2'b00} +: 4];
    assign b_dig    = b_q[{idx, 2'b00} +: 4];
    assign slice    = bcd_digit_add(a_dig, b_dig, carry);
    assign bad_dig  = (a_dig > 4'd9) || (b_dig > 4'd9);
    assign last_dig = (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        carry     <= carry_in;
                        sum       <= '0;
                        carry_out <= 1'b0;
                        error     <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    sum[{idx, 2'b00} +: 4] <= slice[3:0];
                    carry                  <= slice[4];
                    if (bad_dig)
                        error <= 1'b1;
                    if (last_dig) begin
                        carry_out <= slice[4];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Start is ignored here; the next request is taken in IDLE.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_digit_sequencer.sv
module tb_bcd_serial_digit_sequencer;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         error;

    logic         start1;
    logic [3:0]   a1;
    logic [3:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [3:0]   sum1;
    logic         carry_out1;
    logic         error1;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_serial_digit_sequencer #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(cin),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .error(error)
    );

    bcd_serial_digit_sequencer #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(carry_out1), .error(error1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Whole-operation reference: returns {error, carry_out, sum}.
    function automatic logic [W+1:0] model_add(input logic [W-1:0] av,
                                               input logic [W-1:0] bv,
                                               input logic cv);
        int c, s, da, db, dig;
        logic [W-1:0] r;
        logic e;
        c = int'(cv);
        r = '0;
        e = 1'b0;
        for (int i = 0; i < D; i++) begin
            da = int'(av[4*i +: 4]);
            db = int'(bv[4*i +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            s = da + db + c;
            if (s > 9) begin
                dig = (s + 6) % 16;
                c = 1;
            end else begin
                dig = s;
                c = 0;
            end
            r[4*i +: 4] = 4'(dig);
        end
        return {e, c[0], r};
    endfunction

    // Cycle-level expectation: idle / busy for D cycles / done for one cycle.
    int           m_phase = 0;
    int           m_left  = 0;
    logic         m_busy  = 1'b0;
    logic         m_done  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_co    = 1'b0;
    logic         m_err   = 1'b0;
    logic [W+1:0] m_pend  = '0;
    bit           chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_sum <= '0; m_co <= 1'b0; m_err <= 1'b0; chk_en <= 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pend  <= model_add(a, b, cin);
                m_sum   <= '0; m_co <= 1'b0; m_err <= 1'b0;
                m_busy  <= 1'b1;
                m_left  <= D;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_sum   <= m_pend[W-1:0];
                m_co    <= m_pend[W];
                m_err   <= m_pend[W+1];
                m_phase <= 2;
            end
        end else begin
            m_done  <= 1'b0;
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            if (!m_busy) begin
                check("sum", 64'(sum), 64'(m_sum));
                check("carry_out", 64'(carry_out), 64'(m_co));
                check("error", 64'(error), 64'(m_err));
            end
        end
    end

    // Waits (bounded) for done; cyc counts negedges from the caller's negedge.
    task automatic wait_done(input bit hold, output logic [W-1:0] s, output logic co,
                             output logic er, output int cyc, output int bcnt);
        bit got;
        got = 1'b0; cyc = 0; bcnt = 0; s = '0; co = 1'b0; er = 1'b0;
        while (cyc < 30 && !got) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (done) begin
                got = 1'b1; s = sum; co = carry_out; er = error;
            end else if (busy) begin
                bcnt++;
            end
        end
        check("done_timeout", 64'(got), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          output logic [W-1:0] s, output logic co, output logic er,
                          output int cyc, output int bcnt);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        wait_done(1'b0, s, co, er, cyc, bcnt);
    endtask

    initial begin
        logic [W-1:0] s;
        logic co, er;
        int cyc, bcnt, dcount;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, s, co, er, cyc, bcnt);
        check("t1_sum", 64'(s), 64'h6912);
        check("t1_co", 64'(co), 64'd0);
        check("t1_err", 64'(er), 64'd0);
        check("t1_latency", 64'(cyc), 64'd5);
        check("t1_busy_cycles", 64'(bcnt), 64'd4);

        run_op(16'h9999, 16'h0001, 1'b0, s, co, er, cyc, bcnt);
        check("t2_sum", 64'(s), 64'h0000);
        check("t2_co", 64'(co), 64'd1);
        run_op(16'h9999, 16'h9999, 1'b1, s, co, er, cyc, bcnt);
        check("t3_sum", 64'(s), 64'h9999);
        check("t3_co", 64'(co), 64'd1);

        // Invalid digit 2 (A): 10+0 corrected to 0 with a carry into digit 3.
        run_op(16'h0A00, 16'h0000, 1'b0, s, co, er, cyc, bcnt);
        check("t4_err", 64'(er), 64'd1);
        check("t4_sum", 64'(s), 64'h1000);
        check("t4_co", 64'(co), 64'd0);
        run_op(16'h0001, 16'h0002, 1'b0, s, co, er, cyc, bcnt);
        check("t5_err_cleared", 64'(er), 64'd0);
        check("t5_sum", 64'(s), 64'h0003);

        // Start held high, A changed after acceptance.
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h1111;
        check("t6_busy", 64'(busy), 64'd1);
        wait_done(1'b1, s, co, er, cyc, bcnt);
        check("t6_sum", 64'(s), 64'h0010);
        @(negedge clk);
        check("t6_no_restart_busy", 64'(busy), 64'd0);
        check("t6_single_done", 64'(done), 64'd0);
        wait_done(1'b0, s, co, er, cyc, bcnt);
        check("t7_sum", 64'(s), 64'h1116);
        check("t7_busy_cycles", 64'(bcnt), 64'd4);

        // Reset sampled at edge 2 of an operation.
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t8_busy", 64'(busy), 64'd0);
        check("t8_done", 64'(done), 64'd0);
        check("t8_sum", 64'(sum), 64'd0);
        check("t8_co", 64'(carry_out), 64'd0);
        check("t8_err", 64'(error), 64'd0);
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("t8_no_done", 64'(dcount), 64'd0);
        run_op(16'h0808, 16'h0303, 1'b1, s, co, er, cyc, bcnt);
        check("t9_sum", 64'(s), 64'h1112);

        // Single-digit instance.
        @(negedge clk);
        a1 = 4'h7; b1 = 4'h8; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("d1_busy", 64'(busy1), 64'd1);
        check("d1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        check("d1_done", 64'(done1), 64'd1);
        check("d1_sum", 64'(sum1), 64'h6);
        check("d1_co", 64'(carry_out1), 64'd1);
        check("d1_err", 64'(error1), 64'd0);
        @(negedge clk);
        a1 = 4'h9; b1 = 4'hF; cin1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("d1b_sum", 64'(sum1), 64'hE);
        check("d1b_co", 64'(carry_out1), 64'd1);
        check("d1b_err", 64'(error1), 64'd1);

        // Randomised operations with input noise during processing.
        for (int it = 0; it < 40; it++) begin
            logic [W-1:0] ra, rb;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                start = 1'b0;
            end
            for (int k = 0; k < D; k++) begin
                ra[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
                rb[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            end
            @(negedge clk);
            a = ra; b = rb; cin = 1'($urandom); start = 1'b1;
            repeat (D + 1) begin
                @(negedge clk);
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                start = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (D + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
